// File: rtl/alu_mc_pkg.sv
// rtl/alu_mc_pkg.sv - opcode and state types shared by the multi-cycle ALU
package alu_mc_pkg;

    typedef enum logic [4:0] {
        OP_ADD  = 5'd0,
        OP_ADDC = 5'd1,
        OP_SUB  = 5'd2,
        OP_SUBC = 5'd3,
        OP_CMP  = 5'd4,
        OP_AND  = 5'd5,
        OP_OR   = 5'd6,
        OP_XOR  = 5'd7,
        OP_TEST = 5'd8,
        OP_LSL  = 5'd9,
        OP_LSR  = 5'd10,
        OP_ROL  = 5'd11,
        OP_ROR  = 5'd12,
        OP_ASR  = 5'd13,
        OP_MOV  = 5'd14,
        OP_NOP  = 5'd15,
        OP_MUL  = 5'd16,
        OP_DIV  = 5'd17
    } opcode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    // Single-cycle opcodes that store their result; CMP/TEST/NOP only touch flags
    function automatic logic writes_res(input logic [4:0] op);
        return (op <= OP_MOV) && (op != OP_CMP) && (op != OP_TEST);
    endfunction

    // Opcodes that run the iterative shift-add / restoring loop
    function automatic logic is_multi(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational single-cycle ALU datapath
module alu_core #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [4:0]       op,
    output logic [WIDTH:0]   res,
    output logic             c,
    output logic             z
);
    import alu_mc_pkg::*;

    logic [WIDTH:0] ax;
    logic [WIDTH:0] bx;
    logic [WIDTH:0] cx;

    assign ax = {1'b0, a};
    assign bx = {1'b0, b};
    assign cx = {{WIDTH{1'b0}}, cin};

    // Every op is formed at WIDTH+1 bits; the top bit is the carry, borrow or shifted-out bit
    always_comb begin
        res = '0;
        case (op)
            OP_ADD:          res = ax + bx;
            OP_ADDC:         res = ax + bx + cx;
            OP_SUB, OP_CMP:  res = ax - bx;
            OP_SUBC:         res = ax - bx - cx;
            OP_AND, OP_TEST: res = ax & bx;
            OP_OR:           res = ax | bx;
            OP_XOR:          res = ax ^ bx;
            OP_LSL:          res = {a, cin};
            OP_LSR:          res = {a[0], cin, a[WIDTH-1:1]};
            OP_ROL:          res = {a, a[WIDTH-1]};
            OP_ROR:          res = {a[0], a[0], a[WIDTH-1:1]};
            OP_ASR:          res = {a[0], a[WIDTH-1], a[WIDTH-1:1]};
            OP_MOV:          res = bx;
            default:         res = '0;
        endcase
    end

    assign c = res[WIDTH];
    assign z = (res[WIDTH-1:0] == '0);

endmodule

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle ALU with iterative unsigned multiply and divide
module alu_mc #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    input  logic [4:0]       SEL,
    output logic [WIDTH-1:0] RES,
    output logic [WIDTH-1:0] RES_HI,
    output logic             C,
    output logic             Z,
    output logic             BUSY,
    output logic             DONE
);
    import alu_mc_pkg::*;

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nx;
    logic [CW-1:0]    cnt;
    logic [4:0]       op_q;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] opnd;

    logic [WIDTH:0]   core_res;
    logic             core_c;
    logic             core_z;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH+1:0] div_diff;
    logic [WIDTH-1:0] nx_hi;
    logic [WIDTH-1:0] nx_lo;
    logic             spare_unused;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .a   (A),
        .b   (B),
        .cin (CIN),
        .op  (SEL),
        .res (core_res),
        .c   (core_c),
        .z   (core_z)
    );

    // These bits are provably zero or duplicated by the carry output
    assign spare_unused = core_res[WIDTH] ^ div_diff[WIDTH];

    // One loop step: hi/lo are product-high/multiplier for MUL, remainder/quotient for DIV
    always_comb begin
        mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        div_shift = {hi, lo[WIDTH-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, opnd};
        nx_hi     = div_shift[WIDTH-1:0];
        nx_lo     = {lo[WIDTH-2:0], 1'b0};
        if (op_q == OP_MUL) begin
            nx_hi = mul_sum[WIDTH:1];
            nx_lo = {mul_sum[0], lo[WIDTH-1:1]};
        end else if (!div_diff[WIDTH+1]) begin
            nx_hi = div_diff[WIDTH-1:0];
            nx_lo = {lo[WIDTH-2:0], 1'b1};
        end
    end

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nx;
    end

    // Next state: loop ops dwell WIDTH cycles in RUN, everything else goes straight to FIN
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (START) state_nx = is_multi(SEL) ? RUN : FIN;
            RUN:     if (cnt == LAST) state_nx = FIN;
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign BUSY = (state != IDLE);
    assign DONE = (state == FIN);

    // Operand capture, loop iteration and result/flag update on entry to FIN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            RES    <= '0;
            RES_HI <= '0;
            C      <= 1'b0;
            Z      <= 1'b0;
            cnt    <= '0;
            op_q   <= '0;
            hi     <= '0;
            lo     <= '0;
            opnd   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (START) begin
                        if (is_multi(SEL)) begin
                            op_q <= SEL;
                            cnt  <= '0;
                            hi   <= '0;
                            lo   <= A;
                            opnd <= B;
                        end else begin
                            if (writes_res(SEL)) RES <= core_res[WIDTH-1:0];
                            C <= core_c;
                            Z <= core_z;
                        end
                    end
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    hi  <= nx_hi;
                    lo  <= nx_lo;
                    if (cnt == LAST) begin
                        RES    <= nx_lo;
                        RES_HI <= nx_hi;
                        if (op_q == OP_MUL) begin
                            C <= 1'b0;
                            Z <= ({nx_hi, nx_lo} == '0);
                        end else begin
                            C <= (opnd == '0);
                            Z <= (nx_lo == '0);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (legal range 4..32).
REQ-002 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port RST, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port START, input, 1 bit: request to begin an operation using the current A, B, CIN and SEL.
REQ-005 The block SHALL have ports A and B, input, WIDTH bits each: the operands, captured on the accepted START.
REQ-006 The block SHALL have port CIN, input, 1 bit: carry/shift-in bit, captured on the accepted START.
REQ-007 The block SHALL have port SEL, input, 5 bits: the opcode, captured on the accepted START.
REQ-008 The block SHALL have port RES, output, WIDTH bits: the registered primary result.
REQ-009 The block SHALL have port RES_HI, output, WIDTH bits: the registered product high half or remainder.
REQ-010 The block SHALL have ports C and Z, output, 1 bit each: the registered carry and zero flags.
REQ-011 The block SHALL have port BUSY, output, 1 bit: high while an operation is in flight.
REQ-012 The block SHALL have port DONE, output, 1 bit: a one-cycle pulse when results and flags update.

Function
REQ-013 The block SHALL implement a state machine with states IDLE, RUN and FIN; START is accepted only in IDLE, and START in RUN or FIN SHALL be ignored.
REQ-014 Single-cycle opcodes 0-15 SHALL go IDLE->FIN on an accepted START, so that DONE is high in the cycle after START (latency 1).
REQ-015 Opcodes 0-15 SHALL be, in order: ADD, ADDC, SUB, SUBC, CMP, AND, OR, XOR, TEST, LSL, LSR, ROL, ROR, ASR, MOV(B) and NOP.
REQ-016 All single-cycle opcodes SHALL compute at WIDTH+1 bits, with C taken from bit WIDTH; logic ops and MOV SHALL give C=0, and the shift and rotate ops SHALL give C equal to the bit shifted out.
REQ-017 CMP and TEST SHALL update only C and Z; RES and RES_HI SHALL keep their previous values.
REQ-018 Opcode 16 (MUL, unsigned) SHALL use a shift-add loop of exactly WIDTH RUN cycles, giving {RES_HI,RES} = A*B and C=0.
REQ-019 Opcode 17 (DIV, unsigned) SHALL use a restoring loop of exactly WIDTH RUN cycles, giving RES = quotient, RES_HI = remainder and C=0.
REQ-020 MUL and DIV SHALL take the path IDLE->RUN(WIDTH cycles)->FIN, with DONE high exactly WIDTH+1 cycles after START.
REQ-021 DIV with B=0 SHALL still take WIDTH+1 cycles and give RES = all ones, RES_HI = A and C=1.
REQ-022 Opcodes 18-31 SHALL behave as NOP: latency 1, RES and RES_HI unchanged, C=0, Z=1.
REQ-023 Z SHALL be 1 iff the result is zero; for MUL this is over the full 2*WIDTH product, for DIV over the quotient, and for CMP/TEST over the unstored result.
REQ-024 BUSY SHALL be high in RUN and FIN and low in IDLE; FIN SHALL always return to IDLE after one cycle.
REQ-025 RES, RES_HI, C and Z SHALL change only in the cycle DONE is high, and SHALL otherwise hold.
REQ-026 Input changes after an accepted START SHALL NOT affect the operation in flight.

Reset
REQ-027 RST high SHALL immediately force state IDLE, RES=0, RES_HI=0, C=0, Z=0, BUSY=0, DONE=0 and clear the loop counter and work registers, including during RUN.
REQ-028 An operation aborted by reset SHALL produce no DONE pulse, and START in the first clock edge after RST deasserts SHALL be accepted.

Structure
REQ-029 Package alu_mc_pkg SHALL hold the opcode enum (5-bit) and the state enum (IDLE, RUN, FIN).
REQ-030 The combinational single-cycle datapath SHALL be a sub-module alu_core (parameter WIDTH) returning the WIDTH+1-bit result, C and Z; the MUL/DIV loop and the FSM SHALL live in alu_mc.

Verification
REQ-031 WIDTH=8, ADD A=0xFF B=0x01 -> DONE one cycle later, RES=0x00, C=1, Z=1.
REQ-032 WIDTH=8, MUL A=0xFF B=0xFF -> DONE at cycle 9, RES_HI=0xFE, RES=0x01, Z=0; BUSY high for cycles 1-9.
REQ-033 WIDTH=8, DIV A=200 B=7 -> RES=28, RES_HI=4; DIV A=0x55 B=0 -> RES=0xFF, RES_HI=0x55, C=1 at cycle 9.
REQ-034 CMP A=0x10 B=0x10 after a prior RES=0x3C -> C=0, Z=1, RES still 0x3C.
REQ-035 START pulsed again mid-MUL -> ignored, single DONE; RST asserted in RUN cycle 4 -> all outputs 0 at once, no DONE.
REQ-036 WIDTH=16, SUBC A=0x0000 B=0x0000 CIN=1 -> RES=0xFFFF, C=1, Z=0.
